// File: rtl/ls_arbiter.sv
// Local store arbiter: LSU / instruction fetch / preload share one 128-bit port.
// Optional LS_ARB_STATS_EN macro adds 32-bit grant statistics counters.
module ls_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 128,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [0:ADDR_W-1] lsu_addr,
    input  logic [0:DATA_W-1] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [0:DATA_W-1] lsu_rdata,
    input  logic              if_req,
    input  logic [0:ADDR_W-1] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [0:DATA_W-1] if_rdata,
    input  logic              pl_req,
    input  logic [0:ADDR_W-1] pl_addr,
    input  logic [0:DATA_W-1] pl_wdata,
    output logic              pl_gnt,
    output logic              ls_en,
    output logic              ls_we,
    output logic [0:ADDR_W-1] ls_addr,
    output logic [0:DATA_W-1] ls_wdata,
    input  logic [0:DATA_W-1] ls_rdata
`ifdef LS_ARB_STATS_EN
    ,
    output logic [31:0]       stat_lsu_cnt,
    output logic [31:0]       stat_if_cnt,
    output logic [31:0]       stat_pl_cnt,
    output logic [31:0]       stat_starve_cnt
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0]     r_starve_cnt;
    logic              r_rr_pl;
    logic              w_lsu_gnt;
    logic              w_if_gnt;
    logic              w_pl_gnt;
    logic              w_force_if;
    logic              w_rd_issue;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_if;
    logic              w_ret_lsu;
    logic              w_ret_if;
    logic              r_ls_en;
    logic              r_ls_we;
    logic [0:ADDR_W-1] r_ls_addr;
    logic [0:DATA_W-1] r_ls_wdata;
    logic              r_lsu_rvalid;
    logic              r_if_rvalid;
    logic [0:DATA_W-1] r_lsu_rdata;
    logic [0:DATA_W-1] r_if_rdata;

    // Grants are masked while reset is held so every output reads 0 in reset.
    always_comb begin
        w_lsu_gnt  = 1'b0;
        w_if_gnt   = 1'b0;
        w_pl_gnt   = 1'b0;
        w_force_if = 1'b0;
        if (rst) begin
            if (if_req && (r_starve_cnt == STARVE_MAX)) begin
                w_if_gnt   = 1'b1;
                w_force_if = 1'b1;
            end else if (lsu_req) begin
                w_lsu_gnt = 1'b1;
            end else if (if_req && pl_req) begin
                w_pl_gnt = r_rr_pl;
                w_if_gnt = !r_rr_pl;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end else if (pl_req) begin
                w_pl_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
            r_rr_pl      <= 1'b1;
        end else begin
            if (if_req && !w_if_gnt) begin
                if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end
            if (r_rr_pl && w_pl_gnt)       r_rr_pl <= 1'b0;
            else if (!r_rr_pl && w_if_gnt) r_rr_pl <= 1'b1;
        end
    end

    // Command stage: one registered local store access per granted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ls_en    <= 1'b0;
            r_ls_we    <= 1'b0;
            r_ls_addr  <= '0;
            r_ls_wdata <= '0;
        end else begin
            r_ls_en <= w_lsu_gnt | w_if_gnt | w_pl_gnt;
            r_ls_we <= 1'b0;
            if (w_lsu_gnt) begin
                r_ls_we    <= lsu_we;
                r_ls_addr  <= lsu_addr;
                r_ls_wdata <= lsu_wdata;
            end else if (w_if_gnt) begin
                r_ls_addr  <= if_addr;
            end else if (w_pl_gnt) begin
                r_ls_we    <= 1'b1;
                r_ls_addr  <= pl_addr;
                r_ls_wdata <= pl_wdata;
            end
        end
    end

    assign w_rd_issue = (w_lsu_gnt && !lsu_we) || w_if_gnt;
    assign w_ret_lsu  = r_tag_vld[RD_LAT-1] && !r_tag_if[RD_LAT-1];
    assign w_ret_if   = r_tag_vld[RD_LAT-1] && r_tag_if[RD_LAT-1];

    // Read tags ride alongside the store latency; the exiting tag steers ls_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_vld    <= '0;
            r_tag_if     <= '0;
            r_lsu_rvalid <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_lsu_rdata  <= '0;
            r_if_rdata   <= '0;
        end else begin
            r_tag_vld    <= (r_tag_vld << 1) | RD_LAT'(w_rd_issue);
            r_tag_if     <= (r_tag_if << 1) | RD_LAT'(w_if_gnt);
            r_lsu_rvalid <= w_ret_lsu;
            r_if_rvalid  <= w_ret_if;
            if (w_ret_lsu) r_lsu_rdata <= ls_rdata;
            if (w_ret_if)  r_if_rdata  <= ls_rdata;
        end
    end

`ifdef LS_ARB_STATS_EN
    logic [31:0] r_stat_lsu;
    logic [31:0] r_stat_if;
    logic [31:0] r_stat_pl;
    logic [31:0] r_stat_starve;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_lsu    <= '0;
            r_stat_if     <= '0;
            r_stat_pl     <= '0;
            r_stat_starve <= '0;
        end else begin
            if (w_lsu_gnt)  r_stat_lsu    <= r_stat_lsu + 32'd1;
            if (w_if_gnt)   r_stat_if     <= r_stat_if + 32'd1;
            if (w_pl_gnt)   r_stat_pl     <= r_stat_pl + 32'd1;
            if (w_force_if) r_stat_starve <= r_stat_starve + 32'd1;
        end
    end

    assign stat_lsu_cnt    = r_stat_lsu;
    assign stat_if_cnt     = r_stat_if;
    assign stat_pl_cnt     = r_stat_pl;
    assign stat_starve_cnt = r_stat_starve;
`endif

    assign lsu_gnt    = w_lsu_gnt;
    assign if_gnt     = w_if_gnt;
    assign pl_gnt     = w_pl_gnt;
    assign ls_en      = r_ls_en;
    assign ls_we      = r_ls_we;
    assign ls_addr    = r_ls_addr;
    assign ls_wdata   = r_ls_wdata;
    assign lsu_rvalid = r_lsu_rvalid;
    assign lsu_rdata  = r_lsu_rdata;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed bench for ls_arbiter with a one-register synchronous local store stand-in.
module tb_ls_arbiter;

    logic           clk = 1'b0;
    logic           rst;
    logic           lsu_req, lsu_we;
    logic [0:9]     lsu_addr;
    logic [0:127]   lsu_wdata;
    logic           lsu_gnt, lsu_rvalid;
    logic [0:127]   lsu_rdata;
    logic           if_req;
    logic [0:9]     if_addr;
    logic           if_gnt, if_rvalid;
    logic [0:127]   if_rdata;
    logic           pl_req;
    logic [0:9]     pl_addr;
    logic [0:127]   pl_wdata;
    logic           pl_gnt;
    logic           ls_en, ls_we;
    logic [0:9]     ls_addr;
    logic [0:127]   ls_wdata;
    logic [0:127]   ls_rdata = '0;

    logic [127:0]   mem [0:1023];
    int             n_checks = 0;
    int             n_errors = 0;

    localparam logic [127:0] BEEF  = {4{32'hDEADBEEF}};
    localparam logic [127:0] D3FF  = {4{32'hA50003FF}};
    localparam logic [127:0] D000  = {4{32'hA5000000}};

    ls_arbiter dut (
        .clk(clk), .rst(rst),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .pl_req(pl_req), .pl_addr(pl_addr), .pl_wdata(pl_wdata), .pl_gnt(pl_gnt),
        .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ls_en) begin
            if (ls_we) mem[ls_addr] <= ls_wdata;
            else       ls_rdata     <= mem[ls_addr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {4{32'hA5000000 | 32'(i)}};
        rst = 1'b0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0;
        if_req = 0; if_addr = '0;
        pl_req = 0; pl_addr = '0; pl_wdata = '0;

        cyc; smp;
        chk("reset_ctrl", {lsu_gnt, if_gnt, pl_gnt, ls_en, ls_we, lsu_rvalid, if_rvalid}, 0);
        chk("reset_data", {ls_addr, ls_wdata, lsu_rdata, if_rdata}, 0);
        cyc; rst = 1'b1;

        // Idle after reset
        for (int k = 0; k < 10; k++) begin
            smp;
            chk("idle", {lsu_gnt, if_gnt, pl_gnt, ls_en, lsu_rvalid, if_rvalid}, 0);
            cyc;
        end

        // Preload write, then fetch read of the same address
        pl_req = 1; pl_addr = 10'd10; pl_wdata = BEEF;
        smp; chk("pl_gnt", {lsu_gnt, if_gnt, pl_gnt}, 3'b001);
        cyc; pl_req = 0;
        smp; chk("pl_cmd", {ls_en, ls_we}, 2'b11);
        chk("pl_addr", ls_addr, 10); chk("pl_wdata", ls_wdata, BEEF);
        cyc; if_req = 1; if_addr = 10'd10;
        smp; chk("if_gnt", {lsu_gnt, if_gnt, pl_gnt}, 3'b010);
        cyc; if_req = 0;
        smp; chk("if_cmd", {ls_en, ls_we}, 2'b10); chk("if_addr", ls_addr, 10);
        cyc; smp; chk("if_rvalid_early", if_rvalid, 0);
        cyc; smp; chk("if_rvalid", if_rvalid, 1); chk("if_rdata", if_rdata, BEEF);
        cyc; smp; chk("if_rvalid_pulse", if_rvalid, 0); chk("if_rdata_hold", if_rdata, BEEF);

        // All three requesting: IF forced every fifth cycle, PL starved
        cyc;
        lsu_req = 1; lsu_we = 1; lsu_addr = 10'd20; lsu_wdata = {4{32'h12345678}};
        if_req = 1; if_addr = 10'd5;
        pl_req = 1; pl_addr = 10'd30; pl_wdata = {4{32'h0BADF00D}};
        for (int k = 0; k < 10; k++) begin
            smp;
            chk("starve_gnt", {lsu_gnt, if_gnt, pl_gnt}, (k == 4 || k == 9) ? 3'b010 : 3'b100);
            cyc;
        end
        lsu_req = 0; lsu_we = 0; if_req = 0; pl_req = 0;
        cyc; cyc; cyc;

        // IF and PL alternate with LSU idle
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                if_req = 1; if_addr = 10'd5;
                pl_req = 1; pl_addr = 10'd100; pl_wdata = {4{32'h55AA55AA}};
            end else begin
                if_req = 0; pl_req = 0;
            end
            smp;
            if (k < 4) chk("rr_gnt", {lsu_gnt, if_gnt, pl_gnt}, (k % 2 == 0) ? 3'b001 : 3'b010);
            if (k > 0) chk("rr_we", {ls_en, ls_we}, ((k - 1) % 2 == 0) ? 2'b11 : 2'b10);
            cyc;
        end
        cyc; cyc; cyc;

        // Back-to-back LSU read then IF read
        lsu_req = 1; lsu_we = 0; lsu_addr = 10'h3FF;
        smp; chk("b2b_lsu_gnt", lsu_gnt, 1);
        cyc; lsu_req = 0; if_req = 1; if_addr = 10'h000;
        smp; chk("b2b_if_gnt", if_gnt, 1);
        cyc; if_req = 0;
        cyc;
        smp; chk("b2b_ret1", {lsu_rvalid, if_rvalid}, 2'b10); chk("b2b_lsu_rdata", lsu_rdata, D3FF);
        cyc;
        smp; chk("b2b_ret2", {lsu_rvalid, if_rvalid}, 2'b01); chk("b2b_if_rdata", if_rdata, D000);
        cyc; cyc;

        // Reset with an LSU read in flight
        lsu_req = 1; lsu_we = 0; lsu_addr = 10'h3FF;
        smp; chk("rst_lsu_gnt", lsu_gnt, 1);
        cyc; lsu_req = 0; rst = 1'b0;
        #1;
        chk("rst_async_ctrl", {ls_en, ls_we, lsu_rvalid, if_rvalid}, 0);
        chk("rst_async_data", {lsu_rdata, if_rdata}, 0);
        lsu_req = 1;
        #1;
        chk("rst_gnt_masked", {lsu_gnt, if_gnt, pl_gnt}, 0);
        lsu_req = 0;
        cyc; cyc; rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp;
            chk("rst_no_rvalid", {lsu_rvalid, ls_en}, 0);
            cyc;
        end
        chk("rst_rdata_clear", lsu_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
